// File: rtl/mem_access_unit_if.sv
// Memory-stage request channel plus the dmemory32 RAM port of mem_access_unit.
// slave = the access unit itself; master = its surroundings (CPU memory stage and RAM).
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport slave (
    input  req, we, size, sext, addr, wdata, readData,
    output ready, done, rdata, err, memWrite, address, writeData
  );

  modport master (
    output req, we, size, sext, addr, wdata, readData,
    input  ready, done, rdata, err, memWrite, address, writeData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store initiator for a 32-bit RAM; sub-word stores use read-modify-write.
// Optional MEM_MISALIGN_CHECK_EN: misaligned halfword/word requests complete at once with err=1.
module mem_access_unit #(
  parameter int RD_LAT = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} stateT;

  stateT       stateReg, stateNext;
  logic [1:0]  rdCntReg, rdCntNext;
  logic        weReg;
  logic [1:0]  sizeReg;
  logic        sextReg;
  logic [1:0]  offsetReg;
  logic [15:0] wdataReg;

  logic        readyReg, readyNext;
  logic        doneReg, doneNext;
  logic        errReg, errNext;
  logic        memWriteReg, memWriteNext;
  logic [31:0] addressReg, addressNext;
  logic [31:0] writeDataReg, writeDataNext;
  logic [31:0] rdataReg, rdataNext;

  logic        accept;
  logic        misaligned;
  logic        wordStore;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadValue;
  logic [31:0] mergedWord;

  assign accept    = (stateReg == IDLE) && bus.req;
  assign wordStore = bus.we && bus.size[1];

  always_comb begin
`ifdef MEM_MISALIGN_CHECK_EN
    misaligned = (bus.size == 2'd1) ? bus.addr[0] : (bus.size[1] && (bus.addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from the captured RAM word.
  always_comb begin
    laneByte = bus.readData[{offsetReg, 3'b000} +: 8];
    laneHalf = bus.readData[{offsetReg[1], 4'b0000} +: 16];
    unique case (sizeReg)
      2'd0:    loadValue = {{24{sextReg & laneByte[7]}}, laneByte};
      2'd1:    loadValue = {{16{sextReg & laneHalf[15]}}, laneHalf};
      default: loadValue = bus.readData;
    endcase
    mergedWord = bus.readData;
    if (sizeReg == 2'd0) begin
      mergedWord[{offsetReg, 3'b000} +: 8] = wdataReg[7:0];
    end else begin
      mergedWord[{offsetReg[1], 4'b0000} +: 16] = wdataReg;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    rdCntNext     = rdCntReg;
    readyNext     = 1'b0;
    doneNext      = 1'b0;
    errNext       = 1'b0;
    memWriteNext  = 1'b0;
    addressNext   = addressReg;
    writeDataNext = writeDataReg;
    rdataNext     = rdataReg;
    unique case (stateReg)
      IDLE: begin
        readyNext = 1'b1;
        if (bus.req) begin
          readyNext = 1'b0;
          rdCntNext = 2'd0;
          if (misaligned) begin
            stateNext = DONE;
            doneNext  = 1'b1;
            errNext   = 1'b1;
          end else if (wordStore) begin
            stateNext     = WR;
            memWriteNext  = 1'b1;
            addressNext   = {bus.addr[31:2], 2'b00};
            writeDataNext = bus.wdata;
          end else begin
            stateNext   = RD;
            addressNext = {bus.addr[31:2], 2'b00};
          end
        end
      end
      RD: begin
        if (rdCntReg == 2'(RD_LAT - 1)) begin
          stateNext = CAP;
        end else begin
          rdCntNext = rdCntReg + 2'd1;
        end
      end
      CAP: begin
        if (weReg) begin
          stateNext     = WR;
          memWriteNext  = 1'b1;
          writeDataNext = mergedWord;
        end else begin
          stateNext = DONE;
          doneNext  = 1'b1;
          rdataNext = loadValue;
        end
      end
      WR: begin
        stateNext = DONE;
        doneNext  = 1'b1;
      end
      DONE: begin
        stateNext = IDLE;
        readyNext = 1'b1;
      end
      default: begin
        stateNext = IDLE;
        readyNext = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      rdCntReg     <= 2'd0;
      readyReg     <= 1'b1;
      doneReg      <= 1'b0;
      errReg       <= 1'b0;
      memWriteReg  <= 1'b0;
      addressReg   <= 32'd0;
      writeDataReg <= 32'd0;
      rdataReg     <= 32'd0;
    end else begin
      stateReg     <= stateNext;
      rdCntReg     <= rdCntNext;
      readyReg     <= readyNext;
      doneReg      <= doneNext;
      errReg       <= errNext;
      memWriteReg  <= memWriteNext;
      addressReg   <= addressNext;
      writeDataReg <= writeDataNext;
      rdataReg     <= rdataNext;
    end
  end

  // Request fields are held here so the requester may change its inputs right after acceptance.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      weReg     <= 1'b0;
      sizeReg   <= 2'd0;
      sextReg   <= 1'b0;
      offsetReg <= 2'd0;
      wdataReg  <= 16'd0;
    end else if (accept) begin
      weReg     <= bus.we;
      sizeReg   <= bus.size;
      sextReg   <= bus.sext;
      offsetReg <= bus.addr[1:0];
      wdataReg  <= bus.wdata[15:0];
    end
  end

  assign bus.ready     = readyReg;
  assign bus.done      = doneReg;
  assign bus.err       = errReg;
  assign bus.memWrite  = memWriteReg;
  assign bus.address   = addressReg;
  assign bus.writeData = writeDataReg;
  assign bus.rdata     = rdataReg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a behavioural dmemory32 model of RD_LAT read latency.
// Builds with or without MEM_MISALIGN_CHECK_EN; only the misaligned vectors change expectation.
module tb_mem_access_unit;
  localparam int RD_LAT = 2;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  mem_access_unit_if bus();

  mem_access_unit #(.RD_LAT(RD_LAT)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // RAM model: synchronous write, read data valid RD_LAT edges after the address
  bit [31:0] mem [256];
  bit [31:0] pipe [RD_LAT];

  always @(posedge clock) begin
    if (bus.memWrite) mem[bus.address[9:2]] <= bus.writeData;
    pipe[0] <= mem[bus.address[9:2]];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.readData = pipe[RD_LAT-1];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          expLat;
    int          expWrites;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expErr;
    logic [31:0] memAddr;
    logic [31:0] expMem;
  } vecT;

  vecT vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
  task automatic runTxn(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input bit holdReq,
                        output int lat, output int writes, output logic [31:0] wrAddr,
                        output logic [31:0] rd, output logic e, output bit gotDone);
    bit badReady;
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sext = sx; bus.addr = a; bus.wdata = wd;
    @(posedge clock);
    lat = 0; writes = 0; wrAddr = 32'd0; rd = 32'd0; e = 1'b0; gotDone = 1'b0; badReady = 1'b0;
    for (int c = 0; c < 40 && !gotDone; c++) begin
      @(negedge clock);
      if (c == 0) begin
        if (holdReq) begin
          bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'd200; bus.wdata = 32'hDEADBEEF;
        end else begin
          bus.req = 1'b0; bus.we = ~w; bus.size = ~sz; bus.sext = ~sx; bus.addr = ~a; bus.wdata = ~wd;
        end
      end
      lat++;
      if (bus.memWrite) begin
        writes++;
        wrAddr = bus.address;
      end
      if (bus.ready) badReady = 1'b1;
      if (bus.done) begin
        gotDone = 1'b1;
        rd = bus.rdata;
        e = bus.err;
        bus.req = 1'b0;
      end
    end
    check("doneSeen", {31'd0, gotDone}, 32'd1);
    check("readyLowWhileBusy", {31'd0, badReady}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, writes;
    logic [31:0] wrAddr, rd;
    logic        e;
    bit          gotDone, sawWrite, sawDone, sawBusy;

    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sext = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;

    //            we    sz     sx    addr     wdata          lat         wr chk  expRd          err   memAddr  expMem
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'd68,  32'h12345678, 2,          1, 1'b0, 32'h0,         1'b0, 32'd68,  32'h12345678});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'd128, 32'h11223344, 2,          1, 1'b0, 32'h0,         1'b0, 32'd128, 32'h11223344});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd68,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'h12345678,  1'b0, 32'd68,  32'h12345678});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'd69,  32'hFFFFFFAB, RD_LAT + 3, 1, 1'b0, 32'h0,         1'b0, 32'd68,  32'h1234AB78});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'd69,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'hFFFFFFAB,  1'b0, 32'd68,  32'h1234AB78});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'd69,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'h000000AB,  1'b0, 32'd68,  32'h1234AB78});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'd70,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'h00001234,  1'b0, 32'd68,  32'h1234AB78});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'd70,  32'h00008001, RD_LAT + 3, 1, 1'b0, 32'h0,         1'b0, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'd70,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'hFFFF8001,  1'b0, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'd71,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'h00000080,  1'b0, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'd71,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'hFFFFFF80,  1'b0, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd3, 1'b1, 32'd68,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'h8001AB78,  1'b0, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'd68,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'h0000AB78,  1'b0, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'd68,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'hFFFFAB78,  1'b0, 32'd68,  32'h8001AB78});
`ifdef MEM_MISALIGN_CHECK_EN
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'd71,  32'h0,        1,          0, 1'b1, 32'hFFFFAB78,  1'b1, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd70,  32'h0,        1,          0, 1'b1, 32'hFFFFAB78,  1'b1, 32'd68,  32'h8001AB78});
`else
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'd71,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'hFFFF8001,  1'b0, 32'd68,  32'h8001AB78});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'd70,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'h8001AB78,  1'b0, 32'd68,  32'h8001AB78});
`endif
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'd72,  32'hCAFEF00D, 2,          1, 1'b0, 32'h0,         1'b0, 32'd72,  32'hCAFEF00D});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'd75,  32'h0000005A, RD_LAT + 3, 1, 1'b0, 32'h0,         1'b0, 32'd72,  32'h5AFEF00D});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'd72,  32'h1234BEEF, RD_LAT + 3, 1, 1'b0, 32'h0,         1'b0, 32'd72,  32'h5AFEBEEF});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'd74,  32'h0,        RD_LAT + 2, 0, 1'b1, 32'hFFFFFFFE,  1'b0, 32'd72,  32'h5AFEBEEF});

    // Reset state
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("rstReady", {31'd0, bus.ready}, 32'd1);
    check("rstDone", {31'd0, bus.done}, 32'd0);
    check("rstMemWrite", {31'd0, bus.memWrite}, 32'd0);
    check("rstErr", {31'd0, bus.err}, 32'd0);
    check("rstAddress", bus.address, 32'd0);
    check("rstWriteData", bus.writeData, 32'd0);
    check("rstRdata", bus.rdata, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      runTxn(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, 1'b0,
             lat, writes, wrAddr, rd, e, gotDone);
      $display("txn %0d: we=%0b size=%0d sext=%0b addr=%0d wdata=%h -> lat=%0d writes=%0d rdata=%h err=%0b",
               i, vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, lat, writes, rd, e);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      check($sformatf("v%0d writes", i), 32'(writes), 32'(vecs[i].expWrites));
      check($sformatf("v%0d err", i), {31'd0, e}, {31'd0, vecs[i].expErr});
      if (vecs[i].chkRd) check($sformatf("v%0d rdata", i), rd, vecs[i].expRd);
      if (vecs[i].expWrites > 0) check($sformatf("v%0d wrAddr", i), wrAddr, {vecs[i].addr[31:2], 2'b00});
      @(negedge clock);
      check($sformatf("v%0d donePulse", i), {31'd0, bus.done}, 32'd0);
      check($sformatf("v%0d readyAfter", i), {31'd0, bus.ready}, 32'd1);
      check($sformatf("v%0d mem", i), mem[vecs[i].memAddr[9:2]], vecs[i].expMem);
    end

    // A word-store request held high while busy must be dropped, not queued
    runTxn(1'b0, 2'd2, 1'b0, 32'd72, 32'd0, 1'b1, lat, writes, wrAddr, rd, e, gotDone);
    $display("txn held-req: load @72 -> lat=%0d rdata=%h", lat, rd);
    check("heldLatency", 32'(lat), 32'(RD_LAT + 2));
    check("heldRdata", rd, 32'h5AFEBEEF);
    sawWrite = 1'b0; sawBusy = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.memWrite) sawWrite = 1'b1;
      if (!bus.ready) sawBusy = 1'b1;
    end
    check("heldNoWrite", {31'd0, sawWrite}, 32'd0);
    check("heldStaysReady", {31'd0, sawBusy}, 32'd0);
    check("heldMem200", mem[50], 32'd0);

    // Reset during the read phase of a halfword store to 128
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd1; bus.sext = 1'b0; bus.addr = 32'd128; bus.wdata = 32'h0000BEEF;
    @(posedge clock);
    @(negedge clock);
    bus.req = 1'b0;
    sawWrite = bus.memWrite; sawDone = bus.done;
    #2 rst_n = 1'b0;
    #1;
    $display("txn reset-abort: half store @128 aborted in RD");
    check("abortReady", {31'd0, bus.ready}, 32'd1);
    check("abortDone", {31'd0, bus.done}, 32'd0);
    check("abortMemWrite", {31'd0, bus.memWrite}, 32'd0);
    check("abortAddress", bus.address, 32'd0);
    check("abortRdata", bus.rdata, 32'd0);
    check("abortErr", {31'd0, bus.err}, 32'd0);
    check("abortWriteData", bus.writeData, 32'd0);
    repeat (2) begin
      @(negedge clock);
      if (bus.memWrite) sawWrite = 1'b1;
      if (bus.done) sawDone = 1'b1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (bus.memWrite) sawWrite = 1'b1;
      if (bus.done) sawDone = 1'b1;
    end
    check("abortNoWrite", {31'd0, sawWrite}, 32'd0);
    check("abortNoDone", {31'd0, sawDone}, 32'd0);
    check("abortReadyAfter", {31'd0, bus.ready}, 32'd1);
    check("abortMem128", mem[32], 32'h11223344);

    runTxn(1'b0, 2'd2, 1'b0, 32'd128, 32'd0, 1'b0, lat, writes, wrAddr, rd, e, gotDone);
    $display("txn post-reset: load @128 -> lat=%0d rdata=%h", lat, rd);
    check("recoverLatency", 32'(lat), 32'(RD_LAT + 2));
    check("recoverRdata", rd, 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
